// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // A digit at or above the threshold gets the add-3 correction before the shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Digits needed for a width-bit unsigned value: ceil(width * log10(2)).
  // log10(2) is taken as 30103/100000, slightly high but exact for widths 1..32.
  function automatic int min_digits(input int width);
    return (width * 32'sd30103 + 32'sd99999) / 32'sd100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] digit_adj
);

  // Pre-shift correction; max input 9 gives 12, so 4 bits never overflow
  always_comb begin
    if (digit >= BCD_ADJ_THRESH) begin
      digit_adj = digit + BCD_ADJ_ADD;
    end else begin
      digit_adj = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq_chk.sv
// Elaboration-time parameter checks for bin2bcd_seq.
module bin2bcd_seq_chk
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();

  if (WIDTH < 4 || WIDTH > 32) begin : g_width_bad
    $error("bin2bcd_seq: WIDTH must be within 4..32");
  end

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_bad
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one WIDTH-bit operand in, DIGITS packed
// BCD digits out, one shift-and-adjust iteration per clock.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [SW-1:0]   sreg_r;
  logic [SW-1:0]   sreg_next_s;
  logic [CW-1:0]   cnt_r;
  logic [BW-1:0]   bcd_adj_s;
  logic [BW-1:0]   out_bcd_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  // The top digit never needs correction with enough DIGITS, so its MSB is
  // always zero and is shifted out.
  logic            unused_top_msb_s;

  bin2bcd_seq_chk #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_chk ();

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit     (sreg_r[WIDTH + 4*k +: 4]),
      .digit_adj (bcd_adj_s[4*k +: 4])
    );
  end

  // Shift the corrected BCD field and the remaining binary bits left by one
  always_comb begin
    sreg_next_s      = {bcd_adj_s[BW-2:0], sreg_r[WIDTH-1:0], 1'b0};
    unused_top_msb_s = bcd_adj_s[BW-1];
  end

  // Control FSM: operand load, iteration count, result capture, handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sreg_r      <= {SW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_bcd_r   <= {BW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sreg_r     <= {{BW{1'b0}}, in_bin};
            cnt_r      <= CNT_LOAD;
            state_r    <= CONVERT;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CONVERT: begin
          sreg_r <= sreg_next_s;
          if (cnt_r == {CW{1'b0}}) begin
            out_bcd_r   <= sreg_next_s[SW-1:WIDTH];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_bcd   = out_bcd_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq at WIDTH 4, 8 and 16.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  logic rst8_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  in_bin4;
  logic [7:0]  out_bcd4;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_bin8;
  logic [11:0] out_bcd8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] in_bin16;
  logic [19:0] out_bcd16;

  int total;
  int bad;

  bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_bin(in_bin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_bcd(out_bcd4), .busy(busy4));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_bin(in_bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_bcd(out_bcd8), .busy(busy8));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_bin(in_bin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_bcd(out_bcd16), .busy(busy16));

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, packed units-first
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = 20'h0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic run4(input logic [3:0] v, output logic [7:0] res, output int lat);
    int n;
    n = 0;
    in_bin4 = v; in_valid4 = 1'b1;
    while (in_ready4 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_bin4 = 4'($urandom);
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = out_bcd4;
  endtask

  task automatic run8(input logic [7:0] v, output logic [11:0] res, output int lat);
    int n;
    n = 0;
    in_bin8 = v; in_valid8 = 1'b1;
    while (in_ready8 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_bin8 = 8'd255;
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = out_bcd8;
  endtask

  task automatic run16(input logic [15:0] v, output logic [19:0] res, output int lat);
    int n;
    n = 0;
    in_bin16 = v; in_valid16 = 1'b1;
    while (in_ready16 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_bin16 = 16'($urandom);
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = out_bcd16;
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready4, out_valid4, busy4, out_bcd4} !== {3'b100, 8'h00}) begin
      bad++; $display("FAIL reset_w4 got=%b_%h want=100_00", {in_ready4, out_valid4, busy4}, out_bcd4);
    end
    total++;
    if ({in_ready8, out_valid8, busy8, out_bcd8} !== {3'b100, 12'h000}) begin
      bad++; $display("FAIL reset_w8 got=%b_%h want=100_000", {in_ready8, out_valid8, busy8}, out_bcd8);
    end
    total++;
    if ({in_ready16, out_valid16, busy16, out_bcd16} !== {3'b100, 20'h00000}) begin
      bad++; $display("FAIL reset_w16 got=%b_%h want=100_00000", {in_ready16, out_valid16, busy16}, out_bcd16);
    end
  endtask

  task automatic test_w4_all();
    logic [7:0]  res;
    logic [7:0]  res_a [16];
    logic [19:0] exp;
    int lat;
    for (int v = 0; v < 16; v++) begin
      run4(4'(v), res, lat);
      res_a[v] = res;
      exp = ref_bcd(v);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL w4_latency v=%0d got=%0d want=4", v, lat); end
      total++;
      if (res !== exp[7:0]) begin bad++; $display("FAIL w4_value v=%0d got=%h want=%h", v, res, exp[7:0]); end
      @(posedge clk); #1;
      total++;
      if ({out_valid4, in_ready4} !== 2'b01) begin
        bad++; $display("FAIL w4_consume v=%0d got valid,ready=%b want=01", v, {out_valid4, in_ready4});
      end
    end
    total++;
    if ({res_a[10], res_a[15], res_a[9], res_a[0]} !== 32'h10150900) begin
      bad++; $display("FAIL w4_corners got=%h %h %h %h want=10 15 09 00", res_a[10], res_a[15], res_a[9], res_a[0]);
    end
  endtask

  task automatic test_w8_values();
    logic [7:0]  vals [4] = '{8'd255, 8'd128, 8'd99, 8'd0};
    logic [11:0] exps [4] = '{12'h255, 12'h128, 12'h099, 12'h000};
    logic [11:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run8(vals[i], res, lat);
      total++;
      if (lat !== 8) begin bad++; $display("FAIL w8_latency v=%0d got=%0d want=8", vals[i], lat); end
      total++;
      if (res !== exps[i]) begin bad++; $display("FAIL w8_value v=%0d got=%h want=%h", vals[i], res, exps[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [11:0] res;
    int lat;
    int errs;
    out_ready8 = 1'b0;
    run8(8'd200, res, lat);
    total++;
    if (res !== 12'h200) begin bad++; $display("FAIL bp_value got=%h want=200", res); end
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid8 = c[0];
      in_bin8 = 8'($urandom);
      @(posedge clk); #1;
      if ({out_valid8, in_ready8, busy8, out_bcd8} !== {3'b101, 12'h200}) errs++;
    end
    in_valid8 = 1'b0;
    total++;
    if (errs !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", errs); end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid8, in_ready8, busy8, out_bcd8} !== {3'b010, 12'h200}) begin
      bad++; $display("FAIL bp_release got=%b_%h want=010_200", {out_valid8, in_ready8, busy8}, out_bcd8);
    end
  endtask

  task automatic test_input_change();
    logic [11:0] res;
    int lat;
    run8(8'd37, res, lat);
    total++;
    if (res !== 12'h037) begin bad++; $display("FAIL in_change got=%h want=037", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [11:0] res;
    int lat;
    int spurious;
    in_bin8 = 8'd200; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst8_n = 1'b0;
    #1;
    total++;
    if ({in_ready8, out_valid8, busy8, out_bcd8} !== {3'b100, 12'h000}) begin
      bad++; $display("FAIL async_reset got=%b_%h want=100_000", {in_ready8, out_valid8, busy8}, out_bcd8);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst8_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid8 !== 1'b0 || busy8 !== 1'b0) spurious++;
    end
    total++;
    if (spurious !== 0) begin bad++; $display("FAIL post_reset_idle got=%0d active cycles want=0", spurious); end
    run8(8'd42, res, lat);
    total++;
    if (res !== 12'h042) begin bad++; $display("FAIL after_reset got=%h want=042", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_w16_random();
    logic [19:0] res;
    logic [19:0] exp;
    logic [15:0] v;
    int lat;
    run16(16'd65535, res, lat);
    total++;
    if (res !== 20'h65535) begin bad++; $display("FAIL w16_max got=%h want=65535", res); end
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom_range(0, 65535));
      run16(v, res, lat);
      exp = ref_bcd(v);
      total++;
      if (res !== exp || lat !== 16) begin
        bad++; $display("FAIL w16_rand v=%0d got=%h lat=%0d want=%h lat=16", v, res, lat, exp);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; rst_n = 1'b0; rst8_n = 1'b0;
    in_valid4 = 1'b0; in_bin4 = 4'd0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; in_bin8 = 8'd0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; in_bin16 = 16'd0; out_ready16 = 1'b1;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;
    test_w4_all();
    test_w8_values();
    test_backpressure();
    test_input_change();
    test_async_reset();
    test_w16_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
